cpu_core_param: RTL and testbench

- Parametrised successor to the team's single-cycle 8-bit CPU: same 32-bit instruction format and ISA, with configurable data width and register count.
- Adds an explicit 2-state memory-access FSM with registered data-memory requests and a proper busywait handshake.
- Holds the PC and register file on instruction-fetch busywait.
- Sits between the instruction cache and the data cache/memory at the top of the processor.

---
 rtl/cpu_core_param.sv | 157 +++++++++++++++
 tb/tb_cpu_core_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Parametrised single-issue CPU core: loadi/ALU/branch in one cycle, loads/stores through a
// two-state EXEC/MEM_WAIT handshake with registered data-memory requests.
module cpu_core_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 8,
    parameter int unsigned PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_BUSYWAIT,
    output logic              MEMREAD,
    output logic              MEMWRITE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              DATA_BUSYWAIT,
    output logic              ILLEGAL
);
    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;
    localparam logic [7:0] OP_BNE   = 8'd12;

    typedef enum logic {S_EXEC, S_MEM_WAIT} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NREG];
    logic [IDX_W-1:0]  pend_rd, pend_rd_nxt;

    logic [PC_W-1:0]   pc_nxt;
    logic              memread_nxt, memwrite_nxt, illegal_nxt;
    logic [DATA_W-1:0] mem_addr_nxt, writedata_nxt;

    logic              reg_we;
    logic [IDX_W-1:0]  reg_wa;
    logic [DATA_W-1:0] reg_wd;

    logic [7:0]        opcode;
    logic [IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm;
    logic [PC_W-1:0]   pc_plus4, br_target;
    logic              unused_instr;

    // Instruction field decode and asynchronous register reads
    assign opcode       = INSTRUCTION[31:24];
    assign rd_idx       = INSTRUCTION[16 +: IDX_W];
    assign rs1_idx      = INSTRUCTION[8 +: IDX_W];
    assign rs2_idx      = INSTRUCTION[0 +: IDX_W];
    assign imm          = DATA_W'(INSTRUCTION[7:0]);
    assign rs1_val      = regs[rs1_idx];
    assign rs2_val      = regs[rs2_idx];
    assign pc_plus4     = PC + PC_W'(4);
    assign br_target    = pc_plus4 + (PC_W'($signed(INSTRUCTION[23:16])) << 2);
    assign unused_instr = ^INSTRUCTION;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_EXEC;
            PC        <= '0;
            MEMREAD   <= 1'b0;
            MEMWRITE  <= 1'b0;
            MEM_ADDR  <= '0;
            WRITEDATA <= '0;
            ILLEGAL   <= 1'b0;
            pend_rd   <= '0;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            MEMREAD   <= memread_nxt;
            MEMWRITE  <= memwrite_nxt;
            MEM_ADDR  <= mem_addr_nxt;
            WRITEDATA <= writedata_nxt;
            ILLEGAL   <= illegal_nxt;
            pend_rd   <= pend_rd_nxt;
        end
    end

    // Register file: single write port, written only on the retiring edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[reg_wa] <= reg_wd;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = PC;
        memread_nxt   = MEMREAD;
        memwrite_nxt  = MEMWRITE;
        mem_addr_nxt  = MEM_ADDR;
        writedata_nxt = WRITEDATA;
        illegal_nxt   = ILLEGAL;
        pend_rd_nxt   = pend_rd;
        reg_we        = 1'b0;
        reg_wa        = rd_idx;
        reg_wd        = '0;

        case (state)
            S_EXEC: begin
                if (!INSTR_BUSYWAIT) begin
                    pc_nxt = pc_plus4;
                    case (opcode)
                        OP_LOADI: begin reg_we = 1'b1; reg_wd = imm;               end
                        OP_MOV:   begin reg_we = 1'b1; reg_wd = rs2_val;           end
                        OP_ADD:   begin reg_we = 1'b1; reg_wd = rs1_val + rs2_val; end
                        OP_SUB:   begin reg_we = 1'b1; reg_wd = rs1_val + (~rs2_val + DATA_W'(1)); end
                        OP_AND:   begin reg_we = 1'b1; reg_wd = rs1_val & rs2_val; end
                        OP_OR:    begin reg_we = 1'b1; reg_wd = rs1_val | rs2_val; end
                        OP_J:     pc_nxt = br_target;
                        OP_BEQ:   if (rs1_val == rs2_val) pc_nxt = br_target;
                        OP_BNE:   if (rs1_val != rs2_val) pc_nxt = br_target;
                        OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                            // PC holds until the access completes in MEM_WAIT
                            pc_nxt        = PC;
                            state_nxt     = S_MEM_WAIT;
                            mem_addr_nxt  = (opcode == OP_LWD || opcode == OP_SWD) ? rs2_val : imm;
                            writedata_nxt = rs1_val;
                            memread_nxt   = (opcode == OP_LWD || opcode == OP_LWI);
                            memwrite_nxt  = (opcode == OP_SWD || opcode == OP_SWI);
                            pend_rd_nxt   = rd_idx;
                        end
                        default:  illegal_nxt = 1'b1;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                if (!DATA_BUSYWAIT) begin
                    reg_we       = MEMREAD;
                    reg_wa       = pend_rd;
                    reg_wd       = READDATA;
                    memread_nxt  = 1'b0;
                    memwrite_nxt = 1'b0;
                    pc_nxt       = pc_plus4;
                    state_nxt    = S_EXEC;
                end
            end
            default: state_nxt = S_EXEC;
        endcase
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: two widths (8-bit/8 regs, 16-bit/16 regs) share one stimulus stream,
// checked every cycle against an ISA-level model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_cpu_core_param;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_BUSYWAIT, DATA_BUSYWAIT;
    logic [15:0] READDATA;

    logic [31:0] pc8, pc16;
    logic        mr8, mw8, il8, mr16, mw16, il16;
    logic [7:0]  ma8, wd8;
    logic [15:0] ma16, wd16;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    cpu_core_param #(.DATA_W(8), .NREG(8), .PC_W(32)) u8 (
        .CLK(CLK), .RESET(RESET), .PC(pc8), .INSTRUCTION(INSTRUCTION),
        .INSTR_BUSYWAIT(INSTR_BUSYWAIT), .MEMREAD(mr8), .MEMWRITE(mw8),
        .MEM_ADDR(ma8), .WRITEDATA(wd8), .READDATA(READDATA[7:0]),
        .DATA_BUSYWAIT(DATA_BUSYWAIT), .ILLEGAL(il8)
    );

    cpu_core_param #(.DATA_W(16), .NREG(16), .PC_W(32)) u16 (
        .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(INSTRUCTION),
        .INSTR_BUSYWAIT(INSTR_BUSYWAIT), .MEMREAD(mr16), .MEMWRITE(mw16),
        .MEM_ADDR(ma16), .WRITEDATA(wd16), .READDATA(READDATA),
        .DATA_BUSYWAIT(DATA_BUSYWAIT), .ILLEGAL(il16)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ISA-level model, one context per instance (index 0 = 8-bit, 1 = 16-bit)
    bit [31:0] m_pc   [2];
    bit        m_wait [2];
    bit        m_load [2];
    int        m_prd  [2];
    bit        m_rd   [2];
    bit        m_wr   [2];
    bit        m_ill  [2];
    bit [31:0] m_addr [2];
    bit [31:0] m_wd   [2];
    bit [31:0] m_reg  [2][256];

    function automatic bit [31:0] dmask(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_wait[k] = 0; m_load[k] = 0; m_prd[k] = 0;
            m_rd[k] = 0; m_wr[k] = 0; m_ill[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
            for (int r = 0; r < 256; r++) m_reg[k][r] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit [31:0] dm, ra, rb, imm, nx, br;
        bit [7:0]  op;
        int        im, rd, a, b;
        dm = dmask(k);
        im = (k == 0) ? 7 : 15;
        if (!m_wait[k]) begin
            if (INSTR_BUSYWAIT == 1'b0) begin
                op  = INSTRUCTION[31:24];
                rd  = int'(INSTRUCTION[23:16]) & im;
                a   = int'(INSTRUCTION[15:8]) & im;
                b   = int'(INSTRUCTION[7:0]) & im;
                ra  = m_reg[k][a];
                rb  = m_reg[k][b];
                imm = {24'd0, INSTRUCTION[7:0]};
                nx  = m_pc[k] + 32'd4;
                br  = nx + ({{24{INSTRUCTION[23]}}, INSTRUCTION[23:16]} << 2);
                case (op)
                    8'd0:  m_reg[k][rd] = imm & dm;
                    8'd1:  m_reg[k][rd] = rb;
                    8'd2:  m_reg[k][rd] = (ra + rb) & dm;
                    8'd3:  m_reg[k][rd] = (ra - rb) & dm;
                    8'd4:  m_reg[k][rd] = ra & rb;
                    8'd5:  m_reg[k][rd] = ra | rb;
                    8'd6:  nx = br;
                    8'd7:  if (ra == rb) nx = br;
                    8'd12: if (ra != rb) nx = br;
                    8'd8, 8'd9, 8'd10, 8'd11: begin
                        m_wait[k] = 1;
                        m_load[k] = (op < 8'd10);
                        m_rd[k]   = (op < 8'd10);
                        m_wr[k]   = (op >= 8'd10);
                        m_prd[k]  = rd;
                        m_addr[k] = (op == 8'd8 || op == 8'd10) ? rb : imm;
                        m_wd[k]   = ra;
                        nx        = m_pc[k];
                    end
                    default: m_ill[k] = 1;
                endcase
                m_pc[k] = nx;
            end
        end else if (DATA_BUSYWAIT == 1'b0) begin
            if (m_load[k]) m_reg[k][m_prd[k]] = {16'd0, READDATA} & dm;
            m_rd[k]   = 0;
            m_wr[k]   = 0;
            m_wait[k] = 0;
            m_pc[k]   = m_pc[k] + 32'd4;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) model_reset();
            else for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (checking && !RESET) begin
                chk("u8 PC", pc8, m_pc[0]);
                chk("u8 MEMREAD", 32'(mr8), 32'(m_rd[0]));
                chk("u8 MEMWRITE", 32'(mw8), 32'(m_wr[0]));
                chk("u8 ILLEGAL", 32'(il8), 32'(m_ill[0]));
                chk("u16 PC", pc16, m_pc[1]);
                chk("u16 MEMREAD", 32'(mr16), 32'(m_rd[1]));
                chk("u16 MEMWRITE", 32'(mw16), 32'(m_wr[1]));
                chk("u16 ILLEGAL", 32'(il16), 32'(m_ill[1]));
                if (m_rd[0] || m_wr[0]) begin
                    chk("u8 MEM_ADDR", 32'(ma8), m_addr[0]);
                    chk("u8 WRITEDATA", 32'(wd8), m_wd[0]);
                end
                if (m_rd[1] || m_wr[1]) begin
                    chk("u16 MEM_ADDR", 32'(ma16), m_addr[1]);
                    chk("u16 WRITEDATA", 32'(wd16), m_wd[1]);
                end
            end
        end
    end

    logic [31:0] s_mr, s_mw, s_ma8, s_wd8, s_wd16;
    int          req_cycles;

    task automatic exec(input logic [31:0] i);
        @(negedge CLK);
        INSTRUCTION    = i;
        INSTR_BUSYWAIT = 1'b0;
    endtask

    // n edges with INSTR_BUSYWAIT high; the parked instruction must not execute
    task automatic stall(input int n, input logic [31:0] i);
        @(negedge CLK);
        INSTRUCTION    = i;
        INSTR_BUSYWAIT = 1'b1;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic mem(input logic [31:0] i, input int nbusy, input logic [15:0] rdata);
        @(negedge CLK);
        INSTRUCTION    = i;
        INSTR_BUSYWAIT = 1'b0;
        DATA_BUSYWAIT  = (nbusy > 0);
        READDATA       = rdata;
        @(negedge CLK);
        s_mr       = 32'(mr8);
        s_mw       = 32'(mw8);
        s_ma8      = 32'(ma8);
        s_wd8      = 32'(wd8);
        s_wd16     = 32'(wd16);
        req_cycles = int'(mr8 | mw8);
        INSTRUCTION    = 32'h0006_00EE;
        INSTR_BUSYWAIT = 1'b1;
        repeat (nbusy) begin
            @(negedge CLK);
            req_cycles += int'(mr8 | mw8);
        end
        DATA_BUSYWAIT = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; INSTRUCTION = 32'd0; INSTR_BUSYWAIT = 1'b1;
        DATA_BUSYWAIT = 1'b0; READDATA = 16'd0;
        repeat (2) @(negedge CLK);
        chk("reset PC", pc8, 32'd0);
        chk("reset MEMREAD", 32'(mr8), 32'd0);
        chk("reset MEMWRITE", 32'(mw16), 32'd0);
        chk("reset ILLEGAL", 32'(il8), 32'd0);
        chk("reset MEM_ADDR", 32'(ma16), 32'd0);
        chk("reset WRITEDATA", 32'(wd8), 32'd0);
        RESET = 1'b0;
        checking = 1'b1;

        exec(32'h0001_0005);
        exec(32'h0002_0003);
        exec(32'h0203_0102);
        exec(32'h0304_0201);
        stall(1, 32'hFFFF_FFFF);
        chk("PC after 4 ALU ops", pc8, 32'd16);
        mem(32'h0B00_0340, 0, 16'd0);
        chk("swi r3 MEMWRITE", s_mw, 32'd1);
        chk("swi r3 MEM_ADDR", s_ma8, 32'h40);
        chk("r3 add", s_wd8, 32'h08);
        mem(32'h0B00_0441, 0, 16'd0);
        chk("r4 sub u8", s_wd8, 32'hFE);
        chk("r4 sub u16", s_wd16, 32'hFFFE);

        exec(32'h0001_00FF);
        exec(32'h0201_0101);
        exec(32'h0201_0101);
        exec(32'h2A01_0101);
        stall(1, 32'hFFFF_FFFF);
        chk("illegal flag", 32'(il16), 32'd1);
        chk("PC past illegal", pc16, 32'd40);
        mem(32'h0B00_0142, 0, 16'd0);
        chk("r1 doubled u16", s_wd16, 32'h03FC);
        chk("r1 doubled u8", s_wd8, 32'hFC);

        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK);
        chk("ILLEGAL cleared by reset", 32'(il16), 32'd0);
        chk("PC cleared by reset", pc16, 32'd0);
        RESET = 1'b0;

        exec(32'h0601_0000);
        stall(1, 32'hFFFF_FFFF);
        chk("j +1 from 0", pc8, 32'd8);
        exec(32'h07FE_0102);
        stall(1, 32'hFFFF_FFFF);
        chk("beq taken back", pc8, 32'd4);
        exec(32'h0006_0020);
        exec(32'h0CFE_0102);
        stall(1, 32'hFFFF_FFFF);
        chk("bne not taken", pc8, 32'd12);
        exec(32'h0001_005A);
        mem(32'h0B00_0110, 3, 16'd0);
        chk("swi busy MEMWRITE", s_mw, 32'd1);
        chk("swi busy MEM_ADDR", s_ma8, 32'h10);
        chk("swi busy WRITEDATA", s_wd8, 32'h5A);
        chk("swi request edges", 32'(req_cycles), 32'd4);
        stall(2, 32'h0006_0099);
        chk("PC after busy store and stall", pc8, 32'd20);
        mem(32'h0805_0006, 0, 16'h0077);
        chk("lwd MEMREAD", s_mr, 32'd1);
        chk("lwd MEMWRITE", s_mw, 32'd0);
        chk("lwd MEM_ADDR", s_ma8, 32'h20);
        chk("lwd request edges", 32'(req_cycles), 32'd1);
        mem(32'h0B00_0543, 0, 16'd0);
        chk("r5 loaded", s_wd8, 32'h77);
        exec(32'h0C02_0102);
        stall(1, 32'hFFFF_FFFF);
        chk("bne taken", pc8, 32'd40);

        exec(32'h0503_0106);
        exec(32'h0404_0105);
        exec(32'h0107_0001);
        exec(32'hFF00_0000);
        mem(32'h0A00_0407, 0, 16'd0);
        chk("swd address", s_ma8, 32'h5A);
        chk("swd data and", s_wd8, 32'h52);
        mem(32'h0902_0033, 1, 16'hABC3);
        mem(32'h0B00_0244, 0, 16'd0);
        chk("lwi u16", s_wd16, 32'hABC3);
        chk("lwi u8", s_wd8, 32'hC3);
        exec(32'h0305_0201);
        mem(32'h0B00_0546, 0, 16'd0);
        chk("sub after load", s_wd8, 32'h69);

        @(negedge CLK);
        INSTRUCTION = 32'h0805_0006; INSTR_BUSYWAIT = 1'b0; DATA_BUSYWAIT = 1'b1;
        @(negedge CLK);
        INSTR_BUSYWAIT = 1'b1;
        chk("load pending MEMREAD", 32'(mr8), 32'd1);
        #1 RESET = 1'b1;
        #1;
        chk("async reset MEMREAD", 32'(mr8), 32'd0);
        chk("async reset MEMREAD u16", 32'(mr16), 32'd0);
        chk("async reset PC", pc8, 32'd0);
        chk("async reset ILLEGAL", 32'(il8), 32'd0);
        @(negedge CLK);
        RESET = 1'b0; DATA_BUSYWAIT = 1'b0;
        mem(32'h0B00_0545, 0, 16'd0);
        chk("abandoned load dest", s_wd8, 32'h00);
        chk("store after reset addr", s_ma8, 32'h45);
        stall(1, 32'hFFFF_FFFF);
        chk("PC after reset store", pc8, 32'd4);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
